// File: rtl/fifo_drain_scheduler.sv
// fifo_drain_scheduler
// Round-robin scheduler that lets NUM_CH FIFOs share one downstream consumer.
// A channel holds the consumer for up to BURST_LEN beats. It loses the grant
// early if it stalls for IDLE_TIMEOUT cycles or if its enable is dropped.
// Data, valid and ready pass straight through while a grant is held, so this
// block stores no data.

module fifo_drain_scheduler #(
  parameter int WIDTH        = 8,
  parameter int NUM_CH       = 8,
  parameter int BURST_LEN    = 16,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_CH*WIDTH-1:0]   i_ch_data,
  input  logic [NUM_CH-1:0]         i_ch_valid,
  output logic [NUM_CH-1:0]         o_ch_ready,
  input  logic [NUM_CH-1:0]         i_ch_enable,
  output logic [WIDTH-1:0]          o_out_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [$clog2(NUM_CH)-1:0] o_out_chan,
  output logic                      o_out_last,
  output logic                      o_busy
);

  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_LEN - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NUM_CH-1:0] req;
  logic              pick_valid;
  logic [CW-1:0]     pick_idx;
  logic [CW-1:0]     cand;
  logic              beat;
  logic              release_now;

  assign req = i_ch_valid & i_ch_enable;

  // Pick the first requesting channel at or after rr_ptr. The loop walks the
  // offsets from far to near so that the nearest requester is written last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = CW'((int'(rr_ptr_q) + i) % NUM_CH);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // While a grant is held, connect the granted FIFO straight to the output;
  // when idle, every output stays low.
  always_comb begin
    o_ch_ready  = '0;
    o_out_data  = '0;
    o_out_valid = 1'b0;
    o_out_chan  = '0;
    o_out_last  = 1'b0;
    o_busy      = 1'b0;
    if (state_q == ST_GRANT) begin
      o_busy             = 1'b1;
      o_out_chan         = grant_q;
      o_out_data         = i_ch_data[grant_q*WIDTH +: WIDTH];
      o_out_valid        = i_ch_valid[grant_q];
      o_ch_ready[grant_q] = i_out_ready;
      o_out_last         = i_ch_valid[grant_q] && (beat_cnt_q == BEAT_LAST);
    end
  end

  assign beat = o_out_valid & i_out_ready;

  // Next-state logic. Arbitration runs in idle, and release checks run while
  // a grant is held. A beat in the same cycle as an enable drop still counts.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    release_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_GRANT;
          grant_d     = pick_idx;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (beat) begin
          beat_cnt_d  = beat_cnt_q + 1'b1;
          stall_cnt_d = '0;
          if (beat_cnt_q == BEAT_LAST) begin
            release_now = 1'b1;
          end
        end else if (!i_ch_valid[grant_q]) begin
          if (stall_cnt_q == STALL_LAST) begin
            release_now = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
        if (!i_ch_enable[grant_q]) begin
          release_now = 1'b1;
        end
        if (release_now) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == CH_LAST) ? '0 : grant_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers. Reset abandons any burst that is in flight.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// tb_fifo_drain_scheduler
// Randomised bench for fifo_drain_scheduler. Each channel's FIFO is a queue of
// bytes. A transaction-level model of the arbitration rules predicts every
// output beat and pushes it onto a scoreboard. A separate monitor pops each
// beat from the scoreboard and compares it with what the DUT presents.

module tb_fifo_drain_scheduler;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 8;
  localparam int BL     = 4;
  localparam int IT     = 4;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH-1:0]       ch_ready;
  logic [NUM_CH-1:0]       ch_enable;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [2:0]              out_chan;
  logic                    out_last;
  logic                    busy;

  typedef struct packed {
    logic [2:0] chan;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic [7:0] ch_q [NUM_CH][$];
  beat_t      exp_q[$];

  bit m_busy;
  int m_grant;
  int m_beats;
  int m_stall;
  int m_rr;

  int n_checks;
  int n_pass;
  bit mon_en;

  fifo_drain_scheduler #(
    .WIDTH(WIDTH),
    .NUM_CH(NUM_CH),
    .BURST_LEN(BL),
    .IDLE_TIMEOUT(IT)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_ch_data  (ch_data),
    .i_ch_valid (ch_valid),
    .o_ch_ready (ch_ready),
    .i_ch_enable(ch_enable),
    .o_out_data (out_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_chan (out_chan),
    .o_out_last (out_last),
    .o_busy     (busy)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. Every check steps the counters printed in the summary.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bring the model back to its power-up state, in step with a DUT reset.
  task automatic model_reset();
    m_busy  = 1'b0;
    m_grant = 0;
    m_beats = 0;
    m_stall = 0;
    m_rr    = 0;
  endtask

  // One clock cycle of stimulus. On the falling edge, randomise the FIFO
  // heads, enables and ready, and record any beat the model expects. On the
  // rising edge, advance the model through the arbitration rules.
  task automatic apply_stimulus(input int p_gate, input int p_en, input int p_ready, input bit refill);
    beat_t b;
    int    g;
    bit    done;
    @(negedge clk);
    if (refill) begin
      for (int c = 0; c < NUM_CH; c++) begin
        while (ch_q[c].size() < 8) ch_q[c].push_back(8'($urandom));
      end
    end else if ($urandom_range(99) < 25) begin
      ch_q[$urandom_range(NUM_CH - 1)].push_back(8'($urandom));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      ch_valid[c]  = (ch_q[c].size() > 0) && ($urandom_range(99) < p_gate);
      ch_data[c*WIDTH +: WIDTH] = (ch_q[c].size() > 0) ? ch_q[c][0] : 8'($urandom);
      ch_enable[c] = ($urandom_range(99) < p_en);
    end
    out_ready = ($urandom_range(99) < p_ready);
    if (m_busy && ch_valid[m_grant] && out_ready) begin
      b.chan = 3'(m_grant);
      b.data = ch_q[m_grant][0];
      b.last = (m_beats == BL - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
    if (!m_busy) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (m_rr + i) % NUM_CH;
        if (ch_valid[c] && ch_enable[c]) begin
          m_busy  = 1'b1;
          m_grant = c;
          m_beats = 0;
          m_stall = 0;
          break;
        end
      end
    end else begin
      g    = m_grant;
      done = 1'b0;
      if (ch_valid[g] && out_ready) begin
        void'(ch_q[g].pop_front());
        m_beats++;
        m_stall = 0;
        if (m_beats == BL) done = 1'b1;
      end else if (!ch_valid[g]) begin
        m_stall++;
        if (m_stall == IT) done = 1'b1;
      end
      if (!ch_enable[g]) done = 1'b1;
      if (done) begin
        m_busy = 1'b0;
        m_rr   = (g + 1) % NUM_CH;
      end
    end
  endtask

  // Monitor: after each falling edge's inputs settle, compare grant state and
  // ready with the model. When the DUT presents a beat, pop the scoreboard
  // and check the data, channel and last flag.
  initial begin
    logic [NUM_CH-1:0] exp_ready;
    logic              exp_valid;
    logic              exp_last;
    logic              dut_beat;
    beat_t             e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        exp_ready = m_busy ? (NUM_CH'(out_ready) << m_grant) : '0;
        exp_valid = m_busy ? ch_valid[m_grant] : 1'b0;
        exp_last  = exp_valid && (m_beats == BL - 1);
        check_output("busy", busy, m_busy);
        check_output("ch_ready", ch_ready, exp_ready);
        check_output("out_valid", out_valid, exp_valid);
        check_output("out_last", out_last, exp_last);
        if (m_busy) check_output("out_chan", out_chan, m_grant);
        dut_beat = out_valid && out_ready;
        check_output("beat_count", exp_q.size(), dut_beat ? 1 : 0);
        if (dut_beat && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("beat_data", out_data, e.data);
          check_output("beat_chan", out_chan, e.chan);
          check_output("beat_last", out_last, e.last);
        end
        exp_q.delete();
      end
    end
  end

  // Directed phases that use randomised traffic: reset, fairness,
  // random mix, starvation and timeouts, backpressure, and an asynchronous
  // reset in the middle of a burst.
  initial begin
    bit found;
    n_checks  = 0;
    n_pass    = 0;
    mon_en    = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    ch_enable = '1;
    model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 8; k++) ch_q[c].push_back(8'($urandom));
      ch_data[c*WIDTH +: WIDTH] = ch_q[c][0];
    end
    ch_valid = '1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_ch_ready", ch_ready, 0);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_out_chan", out_chan, 0);
    check_output("reset_out_last", out_last, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] fairness phase");
    repeat (60) apply_stimulus(100, 100, 100, 1'b1);

    $display("[TB] random phase");
    repeat (600) apply_stimulus(85, 95, 70, 1'b1);
    repeat (600) apply_stimulus(60, 90, 70, 1'b0);

    $display("[TB] backpressure phase");
    repeat (50) apply_stimulus(100, 100, 0, 1'b1);
    repeat (30) apply_stimulus(100, 100, 100, 1'b1);

    $display("[TB] mid-burst reset");
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      apply_stimulus(100, 100, 100, 1'b1);
      if (m_busy && m_beats == 2) found = 1'b1;
    end
    check_output("midburst_reached", found, 1);
    #2 rst = 1'b1;
    #1;
    check_output("async_busy", busy, 0);
    check_output("async_out_valid", out_valid, 0);
    check_output("async_ch_ready", ch_ready, 0);
    check_output("async_out_last", out_last, 0);
    check_output("async_out_chan", out_chan, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) apply_stimulus(100, 100, 100, 1'b1);
    repeat (100) apply_stimulus(70, 95, 80, 1'b0);

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
